// File: rtl/fp_mul_normalize_pkg.sv
// Shared constants and types for the FP16 multiply normalize/round/pack stage.
// Widths default to binary16; bias and all-ones exponent derive from the exponent width.
package fp_mul_normalize_pkg;

    localparam int FP_FRAC_WIDTH = 10;
    localparam int FP_EXP_WIDTH  = 5;

    typedef enum logic [1:0] {
        NORM_IDLE,
        NORM_SHIFT,
        NORM_ROUND,
        NORM_DONE
    } fpuNormState_t;

    function automatic int exp_bias(input int exp_width);
        return (1 << (exp_width - 1)) - 1;
    endfunction

    function automatic int exp_all_ones(input int exp_width);
        return 2 * exp_bias(exp_width) + 1;
    endfunction

endpackage

// File: rtl/fp_mul_normalize_if.sv
// Operand/result bundle between the mantissa multiplier and the normalize stage.
// The master drives a start pulse with operands; the slave returns the packed result and flags.
interface fp_mul_normalize_if
    import fp_mul_normalize_pkg::*;
#(
    parameter int FRAC_WIDTH = FP_FRAC_WIDTH,
    parameter int EXP_WIDTH  = FP_EXP_WIDTH
);
    logic                                start;
    logic [2*FRAC_WIDTH+1:0]             prodIn;
    logic signed [EXP_WIDTH+1:0]         expSum;
    logic                                signIn;
    logic [EXP_WIDTH+FRAC_WIDTH:0]       result;
    logic                                overflow;
    logic                                underflow;
    logic                                inexact;
    logic                                done;

    modport master (
        output start, prodIn, expSum, signIn,
        input  result, overflow, underflow, inexact, done
    );

    modport slave (
        input  start, prodIn, expSum, signIn,
        output result, overflow, underflow, inexact, done
    );
endinterface

// File: rtl/fp_mul_normalize_round.sv
// Round-to-nearest-even increment of a fraction given its guard and sticky bits.
// Combinational; shared by the multiply and adder paths.
module fpuRoundNearestEven #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] frac,
    input  logic             guard,
    input  logic             sticky,
    output logic [WIDTH-1:0] frac_rounded,
    output logic             carry
);
    logic round_up;

    // NOTE: every output of an always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        round_up = guard & (sticky | frac[0]);
        {carry, frac_rounded} = {1'b0, frac} + {{WIDTH{1'b0}}, round_up};
    end
endmodule

// File: rtl/fp_mul_normalize.sv
// Normalize/round/pack stage for the FP16 multiplier: shifts the raw product one bit per
// cycle until normalized (or denormalized to exponent 1), then rounds and packs binary16.
module fp_mul_normalize
    import fp_mul_normalize_pkg::*;
#(
    parameter int FRAC_WIDTH = FP_FRAC_WIDTH,
    parameter int EXP_WIDTH  = FP_EXP_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    fp_mul_normalize_if.slave  bus
);
    localparam int F  = FRAC_WIDTH;
    localparam int MW = 2 * F + 2;
    localparam int EW = EXP_WIDTH + 3;
    localparam int RW = EXP_WIDTH + F + 1;

    localparam logic signed [EW-1:0] E_ONE      = EW'(1);
    localparam logic signed [EW-1:0] E_ALL_ONES = EW'(exp_all_ones(EXP_WIDTH));

    fpuNormState_t          state;
    logic [MW-1:0]          m;
    logic signed [EW-1:0]   e;
    logic                   s_bit;
    logic                   sign_q;
    logic [RW-1:0]          result_q;
    logic                   overflow_q;
    logic                   underflow_q;
    logic                   inexact_q;
    logic                   done_q;

    logic [F-1:0]           frac_rounded;
    logic                   carry;
    logic                   guard_bit;
    logic                   sticky_all;
    logic                   hidden;
    logic                   exp_nonzero;
    logic signed [EW-1:0]   e_rounded;
    logic [EXP_WIDTH-1:0]   exp_field;
    logic                   overflow_c;
    logic                   inexact_c;

    assign guard_bit  = m[F-1];
    assign sticky_all = (|m[F-2:0]) | s_bit;
    assign hidden     = m[2*F];

    fpuRoundNearestEven #(.WIDTH(F)) u_round (
        .frac         (m[2*F-1:F]),
        .guard        (guard_bit),
        .sticky       (sticky_all),
        .frac_rounded (frac_rounded),
        .carry        (carry)
    );

    // A carry into a subnormal sets the hidden bit; E is already 1 there, so E becomes the field.
    assign exp_nonzero = hidden | carry;
    assign e_rounded   = (carry && hidden) ? e + E_ONE : e;
    assign exp_field   = exp_nonzero ? e_rounded[EXP_WIDTH-1:0] : '0;
    assign overflow_c  = exp_nonzero && (e_rounded >= E_ALL_ONES);
    assign inexact_c   = guard_bit | sticky_all;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the working registers are reset too; they are few bits and keep the stage fully deterministic.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= NORM_IDLE;
            m           <= '0;
            e           <= '0;
            s_bit       <= 1'b0;
            sign_q      <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            inexact_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state)
                NORM_IDLE, NORM_DONE: begin
                    if (bus.start) begin
                        m           <= bus.prodIn;
                        e           <= {bus.expSum[EXP_WIDTH+1], bus.expSum};
                        sign_q      <= bus.signIn;
                        s_bit       <= 1'b0;
                        done_q      <= 1'b0;
                        overflow_q  <= 1'b0;
                        underflow_q <= 1'b0;
                        inexact_q   <= 1'b0;
                        state       <= NORM_SHIFT;
                    end
                end
                NORM_SHIFT: begin
                    if (m == '0) begin
                        state <= NORM_ROUND;
                    end else if (m[MW-1] || e < E_ONE) begin
                        m     <= m >> 1;
                        s_bit <= s_bit | m[0];
                        e     <= e + E_ONE;
                    end else if (!m[2*F] && e > E_ONE) begin
                        m <= m << 1;
                        e <= e - E_ONE;
                    end else begin
                        state <= NORM_ROUND;
                    end
                end
                NORM_ROUND: begin
                    done_q <= 1'b1;
                    state  <= NORM_DONE;
                    if (overflow_c) begin
                        result_q    <= {sign_q, {EXP_WIDTH{1'b1}}, {F{1'b0}}};
                        overflow_q  <= 1'b1;
                        underflow_q <= 1'b0;
                        inexact_q   <= 1'b1;
                    end else begin
                        result_q    <= {sign_q, exp_field, frac_rounded};
                        overflow_q  <= 1'b0;
                        underflow_q <= (exp_field == '0) && inexact_c;
                        inexact_q   <= inexact_c;
                    end
                end
                default: state <= NORM_IDLE;
            endcase
        end
    end

    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
    assign bus.inexact   = inexact_q;
    assign bus.done      = done_q;
endmodule
